// File: rtl/intctl85.sv
// intctl85 - vectored interrupt controller for core85 INTR/INTA_.
//   Latches rising edges on NIRQ request lines and picks the lowest-index
//   unmasked line, with fully nested in-service blocking. It raises intr and,
//   during the INTA_ cycle, drives a one-byte RST opcode.
//   Line k maps to RST(RSTBASE+k).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   irq[NIRQ]      rising-edge requests, synchronous to clk
//   inta_          core85 interrupt acknowledge, active-low
//   cfg_wr/addr    config write: addr 0 = mask (1 = masked), addr 1 = EOI
//   cfg_data[8]    config write data
//   intr           interrupt request to core85
//   data_out/oe    opcode byte and its bus enable
//   pending/insvc  status: latched requests / in-service levels
// Build option: INTCTL85_AUTO_EOI_EN - levels never enter service, EOI ignored.

module intctl85_lane (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_q;

  // A new edge outranks a clear in the same clk, so the request is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq;
      if (irq && !irq_q) pend <= 1'b1;
      else if (clr)      pend <= 1'b0;
    end
  end
endmodule

module intctl85 #(
  parameter int NIRQ    = 4,
  parameter int RSTBASE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            inta_,
  input  logic            cfg_wr,
  input  logic            cfg_addr,
  input  logic [7:0]      cfg_data,
  output logic            intr,
  output logic [7:0]      data_out,
  output logic            data_oe,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] insvc
);
  localparam int SW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

  state_t          state, state_n;
  logic [NIRQ-1:0] mask, insvc_n, cand, pend_clr;
  logic [SW-1:0]   sel, ins_lo, vec, vec_n;
  logic            cand_any, ins_any, cand_ok, ack_done;
  logic            intr_n, oe_n;
  logic [7:0]      dout_n, rst_num;

  for (genvar k = 0; k < NIRQ; k++) begin : g_lane
    intctl85_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq[k]),
      .clr  (pend_clr[k]),
      .pend (pending[k])
    );
  end

  // Lowest-index set bit wins: iterate downward so the last hit is the lowest.
  always_comb begin
    cand     = pending & ~mask;
    sel      = '0;
    cand_any = 1'b0;
    ins_lo   = '0;
    ins_any  = 1'b0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel      = SW'(i);
        cand_any = 1'b1;
      end
      if (insvc[i]) begin
        ins_lo  = SW'(i);
        ins_any = 1'b1;
      end
    end
`ifdef INTCTL85_AUTO_EOI_EN
    cand_ok = cand_any;
`else
    // Fully nested: any in-service level at equal or higher priority blocks.
    cand_ok = cand_any && (!ins_any || (ins_lo > sel));
`endif
  end

  assign rst_num  = 8'(RSTBASE) + 8'(sel);
  assign ack_done = (state == ACK) && inta_;

  always_comb begin
    pend_clr = '0;
    if (ack_done) pend_clr[vec] = 1'b1;
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    oe_n    = 1'b0;
    dout_n  = 8'h00;
    case (state)
      IDLE: begin
        // Spurious acknowledge: answer with a NOP and do not move.
        if (!inta_)       oe_n    = 1'b1;
        else if (cand_ok) state_n = REQ;
      end
      REQ: begin
        if (!cand_ok) state_n = IDLE;
        else if (!inta_) begin
          state_n = ACK;
          vec_n   = sel;
          oe_n    = 1'b1;
          dout_n  = 8'hC7 | (rst_num << 3);
        end
      end
      ACK: begin
        if (inta_) state_n = IDLE;
        else begin
          oe_n   = 1'b1;
          dout_n = data_out;
        end
      end
      default: state_n = IDLE;
    endcase
    intr_n = (state_n == REQ);
  end

  always_comb begin
    insvc_n = insvc;
`ifdef INTCTL85_AUTO_EOI_EN
    insvc_n = '0;
`else
    if (cfg_wr && cfg_addr && ins_any) insvc_n[ins_lo] = 1'b0;
    if (ack_done)                      insvc_n[vec]    = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      intr     <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= 8'h00;
      mask     <= '1;
      insvc    <= '0;
    end else begin
      state    <= state_n;
      vec      <= vec_n;
      intr     <= intr_n;
      data_oe  <= oe_n;
      data_out <= dout_n;
      insvc    <= insvc_n;
      if (cfg_wr && !cfg_addr) mask <= cfg_data[NIRQ-1:0];
    end
  end
endmodule
